// File: rtl/spi_master_cfg.sv
// spi_master_cfg: SPI master with per-transfer mode, bit order and chip-select
// selection.
//
// Ports:
//   sys_clk, rst_n    system clock (rising edge), async active-low reset
//   spi_start         single-cycle request, accepted only while busy = 0
//   cpol, cpha        SPI mode, captured with an accepted spi_start
//   lsb_first         1 = LSB first, captured with an accepted spi_start
//   cs_sel            chip-select mask (one-hot or zero), captured at start
//   data_in           transmit word, captured at start
//   data_out          last received word (holds until the next completion)
//   data_recv_vld     one-cycle pulse when data_out is updated
//   busy              transfer in progress
//   spi_clk, spi_mosi serial clock and data out
//   spi_miso          serial data in
//   spi_csn           active-low chip selects
//
// Sequence: IDLE -> SETUP (1 tick) -> XFER (2*DATA_WIDTH ticks) -> HOLD (1 tick)
// -> GAP (1 tick) -> IDLE, where a tick is CLK_DIV sys_clk cycles.
module spi_master_cfg #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned CS_NUM     = 1
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  spi_start,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [CS_NUM-1:0]     cs_sel,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_recv_vld,
  output logic                  busy,
  output logic                  spi_clk,
  input  logic                  spi_miso,
  output logic                  spi_mosi,
  output logic [CS_NUM-1:0]     spi_csn
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EDGE_W = $clog2(2 * DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [EDGE_W-1:0]     edge_q, edge_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic                  lsb_q, lsb_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  vld_q, vld_d;
  logic                  busy_q, busy_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic [CS_NUM-1:0]     csn_q, csn_d;

  logic                  tick_c;
  logic                  leading_c;
  logic                  last_edge_c;
  logic                  sample_c;
  logic                  advance_c;
  logic [DATA_WIDTH-1:0] tx_shift_c;

  // Bit that goes on the wire first for a given word and bit order.
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  // Half-period tick and per-edge qualifiers.
  always_comb begin
    tick_c      = (div_q == DIV_W'(CLK_DIV - 1));
    leading_c   = ~edge_q[0];
    last_edge_c = (edge_q == EDGE_W'(2 * DATA_WIDTH - 1));
    // cpha=0 samples on leading edges, cpha=1 on trailing edges.
    sample_c    = (leading_c != cpha_q);
    // cpha=0 advances on trailing edges except the last; cpha=1 on leading.
    advance_c   = cpha_q ? leading_c : (~leading_c & ~last_edge_c);
    tx_shift_c  = lsb_q ? (tx_q >> 1) : (tx_q << 1);
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    edge_d  = edge_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    busy_d  = busy_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    csn_d   = csn_q;

    // Divider runs only while a transfer is active and restarts at acceptance.
    if (state_q == IDLE) begin
      div_d = '0;
    end else if (tick_c) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (spi_start) begin
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          tx_d    = data_in;
          rx_d    = '0;
          edge_d  = '0;
          busy_d  = 1'b1;
          csn_d   = ~cs_sel;
          sclk_d  = cpol;
          // cpha=0 needs the first bit valid before the first leading edge.
          mosi_d  = cpha ? 1'b0 : first_bit(data_in, lsb_first);
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (tick_c) begin
          state_d = XFER;
        end
      end

      XFER: begin
        if (tick_c) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_W'(1);
          if (sample_c) begin
            rx_d = lsb_q ? {spi_miso, rx_q[DATA_WIDTH-1:1]}
                         : {rx_q[DATA_WIDTH-2:0], spi_miso};
          end
          if (advance_c) begin
            if (cpha_q) begin
              mosi_d = first_bit(tx_q, lsb_q);
            end else begin
              mosi_d = first_bit(tx_shift_c, lsb_q);
            end
            tx_d = tx_shift_c;
          end
          if (last_edge_c) begin
            edge_d  = '0;
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (tick_c) begin
          csn_d   = '1;
          mosi_d  = 1'b0;
          dout_d  = rx_q;
          vld_d   = 1'b1;
          state_d = GAP;
        end
      end

      GAP: begin
        // Keeps chip selects high for at least one half-period between transfers.
        if (tick_c) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        csn_d   = '1;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csn_q   <= '1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      csn_q   <= csn_d;
    end
  end

  assign data_out      = dout_q;
  assign data_recv_vld = vld_q;
  assign busy          = busy_q;
  assign spi_clk       = sclk_q;
  assign spi_mosi      = mosi_q;
  assign spi_csn       = csn_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg (DATA_WIDTH=8, CLK_DIV=4, CS_NUM=4).
module tb_spi_master_cfg;

  localparam int unsigned DW  = 8;
  localparam int unsigned CD  = 4;
  localparam int unsigned CSN = 4;

  logic           sys_clk = 1'b0;
  logic           rst_n;
  logic           spi_start;
  logic           cpol;
  logic           cpha;
  logic           lsb_first;
  logic [CSN-1:0] cs_sel;
  logic [DW-1:0]  data_in;
  logic [DW-1:0]  data_out;
  logic           data_recv_vld;
  logic           busy;
  logic           spi_clk;
  logic           spi_miso;
  logic           spi_mosi;
  logic [CSN-1:0] spi_csn;

  spi_master_cfg #(.DATA_WIDTH(DW), .CLK_DIV(CD), .CS_NUM(CSN)) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .spi_start     (spi_start),
    .cpol          (cpol),
    .cpha          (cpha),
    .lsb_first     (lsb_first),
    .cs_sel        (cs_sel),
    .data_in       (data_in),
    .data_out      (data_out),
    .data_recv_vld (data_recv_vld),
    .busy          (busy),
    .spi_clk       (spi_clk),
    .spi_miso      (spi_miso),
    .spi_mosi      (spi_mosi),
    .spi_csn       (spi_csn)
  );

  always #5 sys_clk = ~sys_clk;

  // Slave side: loopback, or a mode-0 slave shifting out on falling spi_clk.
  logic          loop_en;
  logic          slv_en;
  logic          slv_lsb;
  logic [DW-1:0] slv_sh;
  assign spi_miso = loop_en ? spi_mosi : (slv_lsb ? slv_sh[0] : slv_sh[DW-1]);

  always @(negedge spi_clk) begin
    if (slv_en) slv_sh = slv_lsb ? (slv_sh >> 1) : (slv_sh << 1);
  end

  // spi_clk edge counters and mosi capture on rising spi_clk.
  logic          mon_en;
  int            n_rise;
  int            n_fall;
  logic [DW-1:0] mosi_cap;

  always @(posedge spi_clk) begin
    if (mon_en) begin
      n_rise   = n_rise + 1;
      mosi_cap = {mosi_cap[DW-2:0], spi_mosi};
    end
  end

  always @(negedge spi_clk) begin
    if (mon_en) n_fall = n_fall + 1;
  end

  // Consecutive cycles with every chip select deasserted.
  int hi_run = 0;
  always @(posedge sys_clk) begin
    hi_run <= (&spi_csn) ? hi_run + 1 : 0;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Results of the most recent transfer.
  int             t_cyc_vld;
  int             t_cyc_idle;
  int             t_nvld;
  int             t_csn_low;
  int             t_gap;
  logic [CSN-1:0] t_csn0;
  logic           t_busy0;
  logic           t_sclk0;

  // Issue one transfer; cycles are counted from the acceptance edge.
  // inj_a/inj_b: cycles at which an extra spi_start is pulsed; rst_at: cycle
  // at which rst_n is pulled low (the task then returns 1 time unit later).
  task automatic run_xfer(input logic pol, input logic pha, input logic lsb,
                          input logic [CSN-1:0] cs, input logic [DW-1:0] din,
                          input int inj_a, input int inj_b, input int rst_at);
    int cyc;
    cpol = pol; cpha = pha; lsb_first = lsb; cs_sel = cs; data_in = din;
    spi_start = 1'b1;
    @(posedge sys_clk); #1;
    spi_start = 1'b0;
    // These must be ignored from here on.
    cpol = ~pol; cpha = ~pha; lsb_first = ~lsb; cs_sel = ~cs; data_in = ~din;
    t_gap = hi_run; t_csn0 = spi_csn; t_busy0 = busy; t_sclk0 = spi_clk;
    n_rise = 0; n_fall = 0; mosi_cap = '0; mon_en = 1'b1;
    if (!loop_en) slv_en = 1'b1;
    t_nvld = 0; t_csn_low = 0; t_cyc_vld = -1; cyc = 0;
    while (busy && cyc < 400) begin
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        break;
      end
      if (spi_csn != '1) t_csn_low = t_csn_low + 1;
      if (cyc == inj_a || cyc == inj_b) spi_start = 1'b1;
      @(posedge sys_clk); #1;
      spi_start = 1'b0;
      cyc = cyc + 1;
      if (data_recv_vld) begin
        t_nvld = t_nvld + 1;
        if (t_cyc_vld < 0) t_cyc_vld = cyc;
        mon_en = 1'b0;
      end
    end
    t_cyc_idle = cyc;
    mon_en = 1'b0;
    slv_en = 1'b0;
  endtask

  initial begin
    int nv;
    logic [1:0] m;
    rst_n = 1'b0; spi_start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    cs_sel = '0; data_in = '0; loop_en = 1'b1; slv_en = 1'b0; slv_lsb = 1'b0;
    slv_sh = '0; mon_en = 1'b0; n_rise = 0; n_fall = 0; mosi_cap = '0;

    // Reset values
    repeat (3) @(posedge sys_clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_csn", 32'(spi_csn), 32'hF);
    check_eq("rst_sclk", 32'(spi_clk), 32'd0);
    check_eq("rst_mosi", 32'(spi_mosi), 32'd0);
    check_eq("rst_dout", 32'(data_out), 32'd0);
    check_eq("rst_vld", 32'(data_recv_vld), 32'd0);
    rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // 1: mode 0, send 55, slave returns A3
    loop_en = 1'b0; slv_lsb = 1'b0; slv_sh = 8'hA3;
    run_xfer(1'b0, 1'b0, 1'b0, 4'b0001, 8'h55, -1, -1, -1);
    check_eq("t1_busy0", 32'(t_busy0), 32'd1);
    check_eq("t1_csn0", 32'(t_csn0), 32'hE);
    check_eq("t1_mosi", 32'(mosi_cap), 32'h55);
    check_eq("t1_rise", 32'(n_rise), 32'd8);
    check_eq("t1_dout", 32'(data_out), 32'hA3);
    check_eq("t1_vld_cyc", 32'(t_cyc_vld), 32'd72);
    check_eq("t1_idle_cyc", 32'(t_cyc_idle), 32'd76);
    check_eq("t1_nvld", 32'(t_nvld), 32'd1);

    // 2: modes 1..3 loopback with C4
    loop_en = 1'b1;
    for (int i = 1; i < 4; i++) begin
      m = 2'(i);
      run_xfer(m[1], m[0], 1'b0, 4'b0001, 8'hC4, -1, -1, -1);
      check_eq($sformatf("t2_m%0d_dout", i), 32'(data_out), 32'hC4);
      check_eq($sformatf("t2_m%0d_rise", i), 32'(n_rise), 32'd8);
      check_eq($sformatf("t2_m%0d_fall", i), 32'(n_fall), 32'd8);
      check_eq($sformatf("t2_m%0d_sclk0", i), 32'(t_sclk0), 32'(m[1]));
      check_eq($sformatf("t2_m%0d_sclk_idle", i), 32'(spi_clk), 32'(m[1]));
    end

    // 3: LSB first, send 01, slave returns 80 LSB first
    loop_en = 1'b0; slv_lsb = 1'b1; slv_sh = 8'h80;
    run_xfer(1'b0, 1'b0, 1'b1, 4'b0001, 8'h01, -1, -1, -1);
    check_eq("t3_mosi", 32'(mosi_cap), 32'h80);
    check_eq("t3_dout", 32'(data_out), 32'h80);

    // 4: starts while busy are ignored; back-to-back start after busy falls
    loop_en = 1'b1;
    run_xfer(1'b0, 1'b0, 1'b0, 4'b0001, 8'h5A, 10, 73, -1);
    check_eq("t4_nvld", 32'(t_nvld), 32'd1);
    check_eq("t4_vld_cyc", 32'(t_cyc_vld), 32'd72);
    check_eq("t4_idle_cyc", 32'(t_cyc_idle), 32'd76);
    check_eq("t4_dout", 32'(data_out), 32'h5A);
    run_xfer(1'b0, 1'b0, 1'b0, 4'b0001, 8'hA5, -1, -1, -1);
    check_eq("t4_b2b_busy0", 32'(t_busy0), 32'd1);
    check_eq("t4_csn_gap", 32'(t_gap), 32'd5);
    check_eq("t4_b2b_dout", 32'(data_out), 32'hA5);

    // 5: chip-select routing and cs_sel = 0
    run_xfer(1'b0, 1'b0, 1'b0, 4'b0100, 8'h96, -1, -1, -1);
    check_eq("t5_csn0", 32'(t_csn0), 32'hB);
    check_eq("t5_csn_low", 32'(t_csn_low), 32'd72);
    check_eq("t5_dout", 32'(data_out), 32'h96);
    run_xfer(1'b0, 1'b0, 1'b0, 4'b0000, 8'h69, -1, -1, -1);
    check_eq("t5_nocs_edges", 32'(n_rise + n_fall), 32'd16);
    check_eq("t5_nocs_low", 32'(t_csn_low), 32'd0);
    check_eq("t5_nocs_nvld", 32'(t_nvld), 32'd1);

    // 6: reset after the 4th bit, then a clean transfer
    run_xfer(1'b0, 1'b0, 1'b0, 4'b0001, 8'hF0, -1, -1, 34);
    check_eq("t6_csn", 32'(spi_csn), 32'hF);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_sclk", 32'(spi_clk), 32'd0);
    check_eq("t6_dout", 32'(data_out), 32'd0);
    nv = 0;
    repeat (5) begin
      @(posedge sys_clk); #1;
      if (data_recv_vld) nv = nv + 1;
    end
    check_eq("t6_no_vld", 32'(nv + t_nvld), 32'd0);
    rst_n = 1'b1;
    @(posedge sys_clk); #1;
    run_xfer(1'b0, 1'b0, 1'b0, 4'b0001, 8'h3C, -1, -1, -1);
    check_eq("t6_dout_after", 32'(data_out), 32'h3C);
    check_eq("t6_vld_cyc", 32'(t_cyc_vld), 32'd72);
    check_eq("t6_nvld", 32'(t_nvld), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_master_cfg.md
Name: spi_master_cfg

Overview:
Parametrised successor to the mode-0-only SPI master. Supports all four SPI modes selectable per transfer, MSB- or LSB-first shifting, generic word width and multiple one-hot chip selects. Returns received word with a valid strike. Sits between a register/control block and off-chip SPI slaves, clocked by the system clock.

Parameters:
DATA_WIDTH, 8, bits per transfer (>=2)
CLK_DIV, 4, sys_clk cycles per spi_clk half-period (>=1); spi_clk = sys_clk/(2*CLK_DIV)
CS_NUM, 1, number of chip-select outputs (>=1)

Ports:
sys_clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
spi_start  input  1  single-cycle request; accepted only when busy=0
cpol  input  1  clock polarity, sampled with spi_start
cpha  input  1  clock phase, sampled with spi_start
lsb_first  input  1  1 = shift LSB first, sampled with spi_start
cs_sel  input  CS_NUM  one-hot (or zero) chip-select mask, sampled with spi_start
data_in  input  DATA_WIDTH  transmit word, sampled with spi_start
data_out  output  DATA_WIDTH  last received word
data_recv_vld  output  1  one-cycle pulse, data_out updated
busy  output  1  transfer in progress
spi_clk  output  1  serial clock
spi_miso  input  1  serial data in
spi_mosi  output  1  serial data out
spi_csn  output  CS_NUM  active-low chip selects

Behaviour:
- Reset (async): state IDLE, busy=0, spi_clk=0, spi_mosi=0, spi_csn=all 1, data_out=0, data_recv_vld=0, latched cpol/cpha/lsb_first/cs_sel/data=0, divider=0.
- Divider counts 0..CLK_DIV-1 only while not IDLE; wrap = one half-period tick. Cleared on start.
- States: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE; each of SETUP, HOLD, GAP lasts exactly one tick (CLK_DIV cycles); XFER lasts 2*DATA_WIDTH ticks.
- IDLE: spi_start=1 at edge E0 latches all config and data_in; after E0 busy=1, spi_csn[i]=~cs_sel[i], spi_clk=latched cpol, state SETUP. spi_start with busy=1 ignored; config inputs ignored outside acceptance edge.
- spi_clk toggles on each XFER tick; edges numbered 1..2*DATA_WIDTH; odd = leading, even = trailing; returns to cpol after last edge.
- cpha=0: first bit on spi_mosi from E0; spi_miso sampled on leading edges; mosi advances on trailing edges except the last.
- cpha=1: mosi advances on leading edges (first bit on edge 1); miso sampled on trailing edges.
- Bit order: lsb_first=0 tx/rx MSB first (rx shifts left); lsb_first=1 LSB first (rx shifts right). Exactly DATA_WIDTH samples taken.
- HOLD end (edge E0+CLK_DIV*(2*DATA_WIDTH+2)): spi_csn all 1, spi_mosi=0, data_out loaded, data_recv_vld=1 for one cycle, state GAP.
- GAP end (E0+CLK_DIV*(2*DATA_WIDTH+3)): busy=0, IDLE. Guarantees csn high >= one half-period between transfers. DATA_WIDTH=8, CLK_DIV=4: vld at +72 cycles, busy low at +76.
- spi_clk in IDLE holds last latched cpol (changes only at acceptance).
- cs_sel=0: transfer runs fully, no csn asserted, vld still pulses. Multi-hot cs_sel drives all selected low (not checked).
- rst_n low mid-transfer: immediate reset values, no vld; next start after release behaves normally.
- data_out holds until next completed transfer.

Test Plan:
1. DATA_WIDTH=8, CLK_DIV=4, mode 0, data_in=8'h55, mode-0 slave model returns 8'hA3 -> mosi 0,1,0,1,0,1,0,1 sampled on 8 rising spi_clk edges; data_out=8'hA3, vld 72 cycles after start, busy low at 76.
2. Modes 1,2,3 with loopback (spi_miso=spi_mosi), data_in=8'hC4 -> data_out=8'hC4 each mode; spi_clk idle level = cpol; exactly 8 sample edges of correct polarity.
3. lsb_first=1, data_in=8'h01, slave sends 8'h80 LSB first -> mosi first bit 1 then seven 0s; data_out=8'h80.
4. spi_start pulsed at +10 and during GAP -> both ignored, single vld; start one cycle after busy falls -> accepted, csn high >=4 cycles between transfers.
5. CS_NUM=4, cs_sel=4'b0100 -> only spi_csn[2] low for 72 cycles; cs_sel=0 -> 16 spi_clk edges, all csn high, vld pulses.
6. rst_n low after 4th bit -> spi_csn all 1, busy 0, spi_clk 0 immediately, no vld; subsequent mode-0 transfer of 8'h3C in loopback returns 8'h3C.
